// File: rtl/sysreg_arb_pkg.sv
// Shared types for the two-port system register bus arbiter.
package sysreg_arb_pkg;

    localparam int SYSREG_ARB_NPORTS = 2;

    typedef logic port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_CAPTURE,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/sysreg_rr_pick.sv
// Combinational round-robin winner select; an active lock restricts the grant to its holder.
module sysreg_rr_pick
    import sysreg_arb_pkg::*;
(
    input  logic [SYSREG_ARB_NPORTS-1:0] req_i,
    input  port_idx_t                    last_gnt_i,
    input  logic                         lock_vld_i,
    input  port_idx_t                    lock_idx_i,
    output port_idx_t                    win_idx_o,
    output logic                         win_vld_o
);

    always_comb begin
        win_vld_o = 1'b0;
        win_idx_o = 1'b0;
        if (lock_vld_i) begin
            win_vld_o = req_i[lock_idx_i];
            win_idx_o = lock_idx_i;
        end else if (req_i[0] && req_i[1]) begin
            win_vld_o = 1'b1;
            win_idx_o = ~last_gnt_i;
        end else if (req_i[0]) begin
            win_vld_o = 1'b1;
            win_idx_o = 1'b0;
        end else if (req_i[1]) begin
            win_vld_o = 1'b1;
            win_idx_o = 1'b1;
        end
    end

endmodule

// File: rtl/sysreg_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 8-bit system register bus.
// Define SYSREG_ARB_LOCK_EN to let a port hold the grant for read-modify-write sequences.
module sysreg_arbiter
    import sysreg_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d_d,
    input  logic [DW-1:0] d_q,
    output logic          read_strobe,
    output logic          write_strobe,
    output logic          busy
);

    arb_state_t    state_q, state_d;
    port_idx_t     gnt_q, gnt_d;
    port_idx_t     last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          rs_q, rs_d;
    logic          ws_q, ws_d;

    port_idx_t     win_idx;
    logic          win_vld;
    logic          lock_vld;

    // The lock holder is always the most recently granted port.
    sysreg_rr_pick u_pick (
        .req_i      ({req1, req0}),
        .last_gnt_i (last_q),
        .lock_vld_i (lock_vld),
        .lock_idx_i (last_q),
        .win_idx_o  (win_idx),
        .win_vld_o  (win_vld)
    );

`ifdef SYSREG_ARB_LOCK_EN
    logic lock_q;
    logic lock_held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q      <= 1'b0;
            lock_held_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && win_vld)
                lock_q <= win_idx ? lock1 : lock0;
            if (state_q == ST_DONE)
                lock_held_q <= lock_q;
        end
    end

    assign lock_vld = lock_held_q;
    assign busy     = (state_q != ST_IDLE) || lock_held_q;
`else
    logic unused_lock;

    assign unused_lock = lock0 | lock1;
    assign lock_vld    = 1'b0;
    assign busy        = (state_q != ST_IDLE);
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        rs_d        = 1'b0;
        ws_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d       = win_idx;
                    we_d        = win_idx ? we1 : we0;
                    bus_addr_d  = win_idx ? addr1 : addr0;
                    bus_wdata_d = win_idx ? wdata1 : wdata0;
                    rs_d        = ~we_d;
                    ws_d        = we_d;
                    state_d     = ST_STROBE;
                end
            end
            ST_STROBE: state_d = we_q ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: begin
                if (gnt_q) rdata1_d = d_q;
                else       rdata0_d = d_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rs_q        <= 1'b0;
            ws_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            rs_q        <= rs_d;
            ws_q        <= ws_d;
        end
    end

    assign ack0         = (state_q == ST_DONE) && (gnt_q == 1'b0);
    assign ack1         = (state_q == ST_DONE) && (gnt_q == 1'b1);
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign a            = bus_addr_q;
    assign d_d          = bus_wdata_q;
    assign read_strobe  = rs_q;
    assign write_strobe = ws_q;

endmodule

// File: doc/sysreg_arbiter.md
# sysreg_arbiter

Two-port arbiter and sequencer for the 8-bit system register bus (`a`, `d_d`, `d_q`, `read_strobe`, `write_strobe`).
- It lets two requesters share the single register file: the host command interface on port 0 and the cartridge-side logic on port 1.
- It generates the single-cycle strobes, captures read data one cycle after the read strobe, and returns a one-cycle acknowledge to the winning requester.
- Grants are round-robin.
- An optional lock feature allows atomic read-modify-write sequences.

## Interface
Parameters:
- `AW`, 8: register address width.
- `DW`, 8: register data width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req0`, `req1`  in  1  transaction request from port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0`, `addr1`  in  AW  register address.
- `wdata0`, `wdata1`  in  DW  write data.
- `lock0`, `lock1`  in  1  hold grant after this transaction (only with `SYSREG_ARB_LOCK_EN`).
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  read result; valid in the `ack` cycle and held until that port's next read completes.
- `a`  out  AW  register bus address.
- `d_d`  out  DW  register bus write data.
- `d_q`  in  DW  register bus read data; registered by the register file on `read_strobe`.
- `read_strobe`, `write_strobe`  out  1  single-cycle bus strobes.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, STROBE, CAPTURE, DONE.
- **IDLE.** If any request is present, pick the winner:
  - If both requests are present, the port not granted last time wins. After reset, port 0 wins.
  - Latch the winner's we/addr/wdata into `a`/`d_d`.
  - Assert `read_strobe` or `write_strobe` (both registered).
  - Go to STROBE.
- **STROBE.** The strobe is high for exactly this cycle and drops next.
  - Write: go to DONE.
  - Read: go to CAPTURE.
- **CAPTURE** (read only). `d_q` is valid in this cycle. Copy it to the granted port's `rdata`, then go to DONE.
- **DONE.** The granted port's `ack` is high for exactly this cycle. Update last-grant, then go to IDLE.
- Requester rule:
  - `req`/`we`/`addr`/`wdata` stay stable from assertion until `ack`.
  - `req` is low in the cycle after `ack` unless a new transaction is intended.
- `read_strobe` and `write_strobe` are never high together.
- At most one `ack` is high in any cycle.
- `a`/`d_d` hold their last value while idle.
- The non-granted port's `rdata` never changes.
- A request arriving mid-transaction waits. It wins in the IDLE cycle that follows DONE, by round-robin.

## Timing
- Write: `req` high in cycle 0 (IDLE) -> `write_strobe` in cycle 1 -> `ack` in cycle 2. Next grant possible in cycle 3.
- Read: `req` in cycle 0 -> `read_strobe` in cycle 1 -> `d_q` captured at the end of cycle 2 -> `ack` + `rdata` in cycle 3.
- Back-to-back alternation under continuous requests: W-W = 3 cycles per transaction; R-R = 4 cycles per transaction.
- Reset values: `read_strobe`=0, `write_strobe`=0, `a`=0, `d_d`=0, `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `busy`=0, state=IDLE, last-grant=port 1.
- Reset mid-transaction:
  - Strobes drop immediately (asynchronously).
  - No `ack` is issued for the aborted transaction.
  - The requester must re-request after reset.
- Reset during STROBE of a write may or may not have committed the write; software treats it as unknown.

## Configuration
Macro: `SYSREG_ARB_LOCK_EN`.

With `SYSREG_ARB_LOCK_EN` defined:
- `lock`x is sampled in IDLE together with `req`x.
- If the granted transaction had lock=1, the next IDLE grants only that port, and the other port's requests wait.
- The hold ends after a transaction by the holder with lock=0.
- `busy` stays high while a lock is held.

Without `SYSREG_ARB_LOCK_EN`:
- `lock0`/`lock1` are ignored (ports kept for a stable interface).
- Pure round-robin.

## Structure
- Package `sysreg_arb_pkg` holds:
  - FSM state enum (IDLE/STROBE/CAPTURE/DONE).
  - `SYSREG_ARB_NPORTS` = 2.
  - Port index type.
- Sub-module `sysreg_rr_pick`: combinational round-robin winner select.
  - Inputs: requests, last-grant, lock-holder.
  - Outputs: winner index, valid.
- Everything else lives in `sysreg_arbiter`.

## Test plan
- Reset, then port 0 writes 0x5A to 0x02 -> `write_strobe` in cycle 1 with `a`=0x02, `d_d`=0x5A; `ack0` in cycle 2. A following port 1 read of 0x02 -> `rdata1`=0x5A with `ack1` 3 cycles after its request.
- Port 0 reads 0x00 and 0x01 -> `rdata0`=0x42, then 0x73. Each `ack` arrives exactly 3 cycles after the request is sampled in IDLE.
- Both ports request reads simultaneously and continuously -> grants alternate 0,1,0,1. Each `ack` is 4 cycles apart, strobes are never overlapping, and the non-granted `rdata` is unchanged.
- Assert `rst` during STROBE of a port 1 read -> `read_strobe` low the same cycle, no `ack1`, all outputs at reset values. Port 0 then wins first after reset.
- With `SYSREG_ARB_LOCK_EN`: port 1 read 0x02 with lock=1 while port 0 requests -> port 1 is granted again for its write 0x02 (lock=0), then port 0 is served. Without the macro, port 0 is served between them.
